// File: rtl/alu_pipe.sv
// Purpose: 8-op ALU with carry/zero flags followed by a STAGES-deep valid-tagged pipeline.
// Latency: STAGES cycles from input transfer to OUT_VALID; one result per cycle when unstalled.
// Backpressure: a held output (OUT_VALID && !OUT_READY) freezes every stage and drops IN_READY.
module alu_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       OP,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [WIDTH-1:0] Y,
  output logic             CO,
  output logic             Z,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [15:0]      TXN_CNT
);

  logic             adv;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] res;
  logic             res_co;

  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] co_q;
  logic [STAGES-1:0] z_q;
  logic [WIDTH-1:0]  y_q [STAGES];

  // Extra top bit gives carry for ADD and borrow (A < B unsigned) for SUB.
  assign sum  = {1'b0, A} + {1'b0, B};
  assign diff = {1'b0, A} - {1'b0, B};

  // Combinational ALU result and carry/borrow flag.
  always_comb begin
    res    = '0;
    res_co = 1'b0;
    case (OP)
      3'd0: res = ~A;
      3'd1: res = ~(A & B);
      3'd2: res = A & B;
      3'd3: res = A | B;
      3'd4: res = A ^ B;
      3'd5: begin
        res    = sum[WIDTH-1:0];
        res_co = sum[WIDTH];
      end
      3'd6: begin
        res    = diff[WIDTH-1:0];
        res_co = diff[WIDTH];
      end
      default: res = B;
    endcase
  end

  assign OUT_VALID = vld[STAGES-1];
  assign Y         = y_q[STAGES-1];
  assign CO        = co_q[STAGES-1];
  assign Z         = z_q[STAGES-1];

  // The whole pipe advances unless the last stage holds a result nobody is taking.
  assign adv      = !(OUT_VALID && !OUT_READY);
  assign IN_READY = adv;

  // Stage registers: stage 0 captures the ALU result, later stages only delay it.
  // Data only loads behind a valid bit so bubbles never disturb the held outputs.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      vld  <= '0;
      co_q <= '0;
      z_q  <= '0;
      for (int s = 0; s < STAGES; s++) begin
        y_q[s] <= '0;
      end
    end else if (adv) begin
      vld[0] <= IN_VALID;
      if (IN_VALID) begin
        y_q[0]  <= res;
        co_q[0] <= res_co;
        z_q[0]  <= (res == '0);
      end
      for (int s = 1; s < STAGES; s++) begin
        vld[s] <= vld[s-1];
        if (vld[s-1]) begin
          y_q[s]  <= y_q[s-1];
          co_q[s] <= co_q[s-1];
          z_q[s]  <= z_q[s-1];
        end
      end
    end
  end

  // Completed output transfers, free-running 16-bit wrap.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      TXN_CNT <= 16'd0;
    end else if (OUT_VALID && OUT_READY) begin
      TXN_CNT <= TXN_CNT + 16'd1;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: vector table streamed back to back, stall, reset and counter wrap sequences.
// Main instance uses WIDTH=8/STAGES=2; a second STAGES=1 instance covers latency-1 and the counter wrap.
// Outputs are sampled 1 time unit after the rising edge; inputs change at the same point.
module tb_alu_pipe;

  logic       clk = 1'b0;
  logic       rst_n, in_valid, in_ready, co, z, out_valid, out_ready;
  logic [7:0] a, b, y;
  logic [2:0] op;
  logic [15:0] txn_cnt;

  logic       rst1, in_valid1, in_ready1, co1, z1, out_valid1, out_ready1;
  logic [7:0] a1, b1, y1;
  logic [2:0] op1;
  logic [15:0] txn_cnt1;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(8), .STAGES(2)) dut (
    .CLK(clk), .RST_N(rst_n), .A(a), .B(b), .OP(op), .IN_VALID(in_valid),
    .IN_READY(in_ready), .Y(y), .CO(co), .Z(z), .OUT_VALID(out_valid),
    .OUT_READY(out_ready), .TXN_CNT(txn_cnt)
  );

  alu_pipe #(.WIDTH(8), .STAGES(1)) dut1 (
    .CLK(clk), .RST_N(rst1), .A(a1), .B(b1), .OP(op1), .IN_VALID(in_valid1),
    .IN_READY(in_ready1), .Y(y1), .CO(co1), .Z(z1), .OUT_VALID(out_valid1),
    .OUT_READY(out_ready1), .TXN_CNT(txn_cnt1)
  );

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] y;
    logic       co;
    logic       z;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] q [$];
    logic [7:0] held;
    logic [7:0] e;
    logic       prev_stall;
    logic       was;
    int         sent, got, n;

    vecs[0]  = '{3'd5, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0};
    vecs[1]  = '{3'd6, 8'h05, 8'h05, 8'h00, 1'b0, 1'b1};
    vecs[2]  = '{3'd6, 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
    vecs[3]  = '{3'd0, 8'hA5, 8'h3C, 8'h5A, 1'b0, 1'b0};
    vecs[4]  = '{3'd1, 8'hA5, 8'h3C, 8'hDB, 1'b0, 1'b0};
    vecs[5]  = '{3'd2, 8'hA5, 8'h3C, 8'h24, 1'b0, 1'b0};
    vecs[6]  = '{3'd3, 8'hA5, 8'h3C, 8'hBD, 1'b0, 1'b0};
    vecs[7]  = '{3'd4, 8'hA5, 8'h3C, 8'h99, 1'b0, 1'b0};
    vecs[8]  = '{3'd5, 8'hA5, 8'h3C, 8'hE1, 1'b0, 1'b0};
    vecs[9]  = '{3'd6, 8'hA5, 8'h3C, 8'h69, 1'b0, 1'b0};
    vecs[10] = '{3'd7, 8'hA5, 8'h3C, 8'h3C, 1'b0, 1'b0};
    vecs[11] = '{3'd2, 8'h0F, 8'hF0, 8'h00, 1'b0, 1'b1};
    vecs[12] = '{3'd5, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1};

    rst1 = 1'b0; in_valid1 = 1'b0; a1 = 8'h01; b1 = 8'h01; op1 = 3'd5; out_ready1 = 1'b1;

    // Reset with a valid input present: it must be discarded.
    rst_n = 1'b0; in_valid = 1'b1; a = 8'h11; b = 8'h22; op = 3'd5; out_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_y", 32'(y), 32'd0);
    chk("rst_co", 32'(co), 32'd0);
    chk("rst_z", 32'(z), 32'd0);
    chk("rst_txn", 32'(txn_cnt), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("rst_discard1", 32'(out_valid), 32'd0);
    tick();
    chk("rst_discard2", 32'(out_valid), 32'd0);

    // Vector table streamed back to back; each result expected 2 edges after its input.
    for (int it = 0; it < NV + 4; it++) begin
      tick();
      if (it >= 2 && it - 2 < NV) begin
        chk($sformatf("vec%0d_valid", it - 2), 32'(out_valid), 32'd1);
        chk($sformatf("vec%0d_y", it - 2), 32'(y), 32'(vecs[it-2].y));
        chk($sformatf("vec%0d_co", it - 2), 32'(co), 32'(vecs[it-2].co));
        chk($sformatf("vec%0d_z", it - 2), 32'(z), 32'(vecs[it-2].z));
        chk($sformatf("vec%0d_txn", it - 2), 32'(txn_cnt), 32'(it - 2));
      end
      if (it == NV + 2) chk("tail_bubble", 32'(out_valid), 32'd0);
      if (it == NV + 3) chk("junk_no_effect_y", 32'(y), 32'(vecs[NV-1].y));
      if (it < NV) begin
        in_valid = 1'b1; op = vecs[it].op; a = vecs[it].a; b = vecs[it].b;
      end else begin
        in_valid = 1'b0; op = 3'($urandom); a = 8'($urandom); b = 8'($urandom);
      end
    end

    // Four-input stream with OUT_READY low for three cycles mid-stream.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    sent = 0; got = 0; prev_stall = 1'b0; held = 8'h00;
    for (int c = 0; c < 40 && got < 4; c++) begin
      out_ready = !(c >= 4 && c <= 6);
      if (sent < 4) begin
        in_valid = 1'b1; op = 3'd5; a = 8'h10 + 8'(sent); b = 8'h01;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid && !out_ready) begin
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        if (prev_stall) chk("stall_y_held", 32'(y), 32'(held));
        held = y;
        prev_stall = 1'b1;
      end else begin
        prev_stall = 1'b0;
      end
      if (out_valid && out_ready) begin
        e = (q.size() > 0) ? q[0] : ~y;
        chk($sformatf("stream_y%0d", got), 32'(y), 32'(e));
        if (q.size() > 0) void'(q.pop_front());
        got++;
      end
      if (in_valid && in_ready) begin
        q.push_back(8'h11 + 8'(sent));
        sent++;
      end
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("stream_delivered", 32'(got), 32'd4);
    chk("stream_txn", 32'(txn_cnt), 32'd4);

    // Reset with two results in flight: none may surface afterwards.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    in_valid = 1'b1; op = 3'd5; a = 8'h40; b = 8'h02;
    tick();
    a = 8'h50;
    tick();
    in_valid = 1'b0;
    chk("inflight_visible", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_txn", 32'(txn_cnt), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("midrst_gone%0d", k), 32'(out_valid), 32'd0);
    end

    // STAGES=1: latency of one edge, then 65536 transfers wrap TXN_CNT to zero.
    in_valid1 = 1'b1;
    rst1 = 1'b1;
    n = 0;
    was = 1'b0;
    for (int c = 0; c < 70000 && n < 65536; c++) begin
      tick();
      if (was) n++;
      if (c == 0) begin
        chk("s1_latency_valid", 32'(out_valid1), 32'd1);
        chk("s1_latency_y", 32'(y1), 32'h02);
        chk("s1_txn0", 32'(txn_cnt1), 32'd0);
      end
      if (was && n == 1) chk("s1_txn1", 32'(txn_cnt1), 32'd1);
      if (was && n == 65535) chk("wrap_ffff", 32'(txn_cnt1), 32'hFFFF);
      if (was && n == 65536) chk("wrap_zero", 32'(txn_cnt1), 32'h0000);
      was = out_valid1 && out_ready1;
    end
    chk("wrap_reached", 32'(n), 32'd65536);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
